// File: rtl/flag_hazard_ctrl.sv
// NZCV flag register with B.cond evaluation in ID and EX->ID flag hazard
// resolution (combinational forwarding or a one-cycle stall FSM).
module flag_hazard_ctrl #(
    parameter bit FWD_EX = 1'b0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_ex,
    input  logic             setFlag_ex,
    input  logic [3:0]       aluFlags_ex,
    input  logic             valid_id,
    input  logic             condBr_id,
    input  logic [3:0]       cond_id,
    input  logic             flush,
    output logic [3:0]       flags,
    output logic             condTrue,
    output logic             stall,
    output logic [CNT_W-1:0] stallCnt
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    state_t     state;
    state_t     next_state;
    logic       commit;
    logic       haz;
    logic [3:0] src_flags;

    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cy;
            4'd3:    return !cy;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cy && !z;
            4'd9:    return !cy || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    // flush squashes EX, so it blocks both the commit and the hazard.
    assign commit = valid_ex & setFlag_ex & ~flush;
    assign haz    = valid_id & condBr_id & commit;

    assign src_flags = (FWD_EX && haz) ? aluFlags_ex : flags;
    assign condTrue  = valid_id & condBr_id & cond_eval(cond_id, src_flags);

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        stall      = 1'b0;
        next_state = RUN;
        if (!FWD_EX) begin
            case (state)
                RUN: begin
                    if (haz) begin
                        stall      = 1'b1;
                        next_state = HOLD;
                    end
                end
                // Bubble sits in EX and flags already hold the committed value.
                HOLD:    next_state = RUN;
                default: next_state = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (reset) begin
            state    <= RUN;
            flags    <= 4'b0000;
            stallCnt <= '0;
        end else begin
            state <= next_state;
            if (commit) begin
                flags <= aluFlags_ex;
            end
            if (stall && (stallCnt != {CNT_W{1'b1}})) begin
                stallCnt <= stallCnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_flag_hazard_ctrl.sv
// Directed bench for flag_hazard_ctrl: stall variant, forwarding variant and
// a narrow-counter stall variant all driven from the same stimulus.
module tb_flag_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_ex;
    logic        setFlag_ex;
    logic [3:0]  aluFlags_ex;
    logic        valid_id;
    logic        condBr_id;
    logic [3:0]  cond_id;
    logic        flush;

    logic [3:0]  flags_s, flags_f, flags_n;
    logic        cond_s, cond_f, cond_n;
    logic        stall_s, stall_f, stall_n;
    logic [15:0] cnt_s, cnt_f;
    logic [3:0]  cnt_n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    flag_hazard_ctrl #(.FWD_EX(1'b0), .CNT_W(16)) dut_stall (
        .clk(clk), .reset(reset), .valid_ex(valid_ex), .setFlag_ex(setFlag_ex),
        .aluFlags_ex(aluFlags_ex), .valid_id(valid_id), .condBr_id(condBr_id),
        .cond_id(cond_id), .flush(flush), .flags(flags_s), .condTrue(cond_s),
        .stall(stall_s), .stallCnt(cnt_s)
    );

    flag_hazard_ctrl #(.FWD_EX(1'b1), .CNT_W(16)) dut_fwd (
        .clk(clk), .reset(reset), .valid_ex(valid_ex), .setFlag_ex(setFlag_ex),
        .aluFlags_ex(aluFlags_ex), .valid_id(valid_id), .condBr_id(condBr_id),
        .cond_id(cond_id), .flush(flush), .flags(flags_f), .condTrue(cond_f),
        .stall(stall_f), .stallCnt(cnt_f)
    );

    flag_hazard_ctrl #(.FWD_EX(1'b0), .CNT_W(4)) dut_narrow (
        .clk(clk), .reset(reset), .valid_ex(valid_ex), .setFlag_ex(setFlag_ex),
        .aluFlags_ex(aluFlags_ex), .valid_id(valid_id), .condBr_id(condBr_id),
        .cond_id(cond_id), .flush(flush), .flags(flags_n), .condTrue(cond_n),
        .stall(stall_n), .stallCnt(cnt_n)
    );

    // Inputs change 1 time unit after the rising edge; outputs are read mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_ex = 0; setFlag_ex = 0; aluFlags_ex = 4'b0000;
        valid_id = 0; condBr_id = 0; cond_id = 4'd0; flush = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
        #1;
    endtask

    task automatic set_hazard(input logic [3:0] alu, input logic [3:0] c);
        valid_ex = 1; setFlag_ex = 1; aluFlags_ex = alu;
        valid_id = 1; condBr_id = 1; cond_id = c;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (flags_s !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", flags_s); end
        total++; if (stall_s !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_s); end
        total++; if (cnt_s !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt_s); end
        valid_id = 1; condBr_id = 1; cond_id = 4'd1;
        #1;
        total++; if (cond_s !== 1'b1) begin bad++; $display("FAIL reset_ne got=%b exp=1", cond_s); end
        total++; if (cond_f !== 1'b1) begin bad++; $display("FAIL reset_ne_fwd got=%b exp=1", cond_f); end
        idle();
    endtask

    task automatic test_commit();
        do_reset();
        valid_ex = 1; setFlag_ex = 1; aluFlags_ex = 4'b0100;
        tick();
        idle();
        #1;
        total++; if (flags_s !== 4'b0100) begin bad++; $display("FAIL commit_flags got=%b exp=0100", flags_s); end
        total++; if (flags_f !== 4'b0100) begin bad++; $display("FAIL commit_flags_fwd got=%b exp=0100", flags_f); end
        valid_id = 1; condBr_id = 1; cond_id = 4'd0;
        #1;
        total++; if (cond_s !== 1'b1) begin bad++; $display("FAIL commit_eq got=%b exp=1", cond_s); end
        total++; if (stall_s !== 1'b0) begin bad++; $display("FAIL commit_stall got=%b exp=0", stall_s); end
        // Flag-setter in EX with a non-branch in ID: no stall, commit still lands.
        valid_ex = 1; setFlag_ex = 1; aluFlags_ex = 4'b1000; condBr_id = 0;
        #1;
        total++; if (stall_s !== 1'b0) begin bad++; $display("FAIL nonbr_stall got=%b exp=0", stall_s); end
        total++; if (cond_s !== 1'b0) begin bad++; $display("FAIL nonbr_cond got=%b exp=0", cond_s); end
        tick();
        idle();
        #1;
        total++; if (flags_s !== 4'b1000) begin bad++; $display("FAIL nonbr_flags got=%b exp=1000", flags_s); end
        // Setter marked invalid must not commit.
        setFlag_ex = 1; aluFlags_ex = 4'b0011;
        tick();
        idle();
        #1;
        total++; if (flags_s !== 4'b1000) begin bad++; $display("FAIL invalid_nocommit got=%b exp=1000", flags_s); end
    endtask

    task automatic test_stall_and_forward();
        do_reset();
        set_hazard(4'b0100, 4'd0);
        #1;
        total++; if (stall_s !== 1'b1) begin bad++; $display("FAIL haz_stall got=%b exp=1", stall_s); end
        total++; if (stall_f !== 1'b0) begin bad++; $display("FAIL haz_stall_fwd got=%b exp=0", stall_f); end
        total++; if (cond_f !== 1'b1) begin bad++; $display("FAIL haz_cond_fwd got=%b exp=1", cond_f); end
        tick();
        valid_ex = 0; setFlag_ex = 0; aluFlags_ex = 4'b0000;
        #1;
        total++; if (stall_s !== 1'b0) begin bad++; $display("FAIL hold_stall got=%b exp=0", stall_s); end
        total++; if (cnt_s !== 16'd1) begin bad++; $display("FAIL hold_cnt got=%0d exp=1", cnt_s); end
        total++; if (flags_s !== 4'b0100) begin bad++; $display("FAIL hold_flags got=%b exp=0100", flags_s); end
        total++; if (cond_s !== 1'b1) begin bad++; $display("FAIL hold_cond got=%b exp=1", cond_s); end
        total++; if (flags_f !== 4'b0100) begin bad++; $display("FAIL fwd_flags got=%b exp=0100", flags_f); end
        total++; if (cnt_f !== 16'd0) begin bad++; $display("FAIL fwd_cnt got=%0d exp=0", cnt_f); end
        tick();
        #1;
        total++; if (stall_s !== 1'b0) begin bad++; $display("FAIL after_hold_stall got=%b exp=0", stall_s); end
        total++; if (cnt_s !== 16'd1) begin bad++; $display("FAIL after_hold_cnt got=%0d exp=1", cnt_s); end
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        set_hazard(4'b0100, 4'd0);
        flush = 1;
        #1;
        total++; if (stall_s !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", stall_s); end
        total++; if (cond_f !== 1'b0) begin bad++; $display("FAIL flush_nofwd got=%b exp=0", cond_f); end
        tick();
        flush = 0;
        #1;
        total++; if (flags_s !== 4'b0000) begin bad++; $display("FAIL flush_flags got=%b exp=0000", flags_s); end
        total++; if (cnt_s !== 16'd0) begin bad++; $display("FAIL flush_cnt got=%0d exp=0", cnt_s); end
        // FSM must still be in RUN: the unflushed hazard stalls right away.
        total++; if (stall_s !== 1'b1) begin bad++; $display("FAIL flush_run got=%b exp=1", stall_s); end
        tick();
        idle();
        reset = 1;
        tick();
        reset = 0;
        #1;
        total++; if (flags_s !== 4'b0000) begin bad++; $display("FAIL rst_hold_flags got=%b exp=0000", flags_s); end
        total++; if (stall_s !== 1'b0) begin bad++; $display("FAIL rst_hold_stall got=%b exp=0", stall_s); end
        total++; if (cnt_s !== 16'd0) begin bad++; $display("FAIL rst_hold_cnt got=%0d exp=0", cnt_s); end
    endtask

    task automatic test_cond_table();
        logic [3:0]  fv [4];
        logic [15:0] ev [4];
        logic [15:0] row;
        fv[0] = 4'b1001; ev[0] = 16'hD65A;
        fv[1] = 4'b1000; ev[1] = 16'hEA9A;
        fv[2] = 4'b0110; ev[2] = 16'hE6A5;
        fv[3] = 4'b0010; ev[3] = 16'hD5A6;
        for (int k = 0; k < 4; k++) begin
            do_reset();
            valid_ex = 1; setFlag_ex = 1; aluFlags_ex = fv[k];
            tick();
            idle();
            valid_id = 1; condBr_id = 1;
            row = ev[k];
            for (int c = 0; c < 16; c++) begin
                cond_id = 4'(c);
                #1;
                total++;
                if (cond_s !== row[c]) begin
                    bad++;
                    $display("FAIL cond flags=%b cond=%0d got=%b exp=%b", fv[k], c, cond_s, row[c]);
                end
            end
        end
        cond_id = 4'd14; condBr_id = 0;
        #1;
        total++; if (cond_s !== 1'b0) begin bad++; $display("FAIL cond_nonbr got=%b exp=0", cond_s); end
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_hazard(4'b0000, 4'd0);
            tick();
            valid_ex = 0; setFlag_ex = 0;
            tick();
        end
        idle();
        #1;
        total++; if (cnt_n !== 4'd15) begin bad++; $display("FAIL sat_cnt4 got=%0d exp=15", cnt_n); end
        total++; if (cnt_s !== 16'd20) begin bad++; $display("FAIL sat_cnt16 got=%0d exp=20", cnt_s); end
        total++; if (cnt_f !== 16'd0) begin bad++; $display("FAIL sat_cnt_fwd got=%0d exp=0", cnt_f); end
    endtask

    initial begin
        reset = 0;
        idle();
        test_reset();
        test_commit();
        test_stall_and_forward();
        test_flush();
        test_cond_table();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
